// File: rtl/window_3x3_gen.sv
// Streaming 3x3 neighbourhood generator: two line buffers plus a 3x3 shift window,
// emitting one window per accepted interior pixel with a one-cycle valid strobe.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | after reset; pixels ignored until pix_valid && sof
// S_ACTIVE | frame in progress; every pix_valid cycle is consumed
// S_DONE   | last pixel seen; pixels ignored until next pix_valid && sof
module window_3x3_gen #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int DW    = 8
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [DW-1:0] i_pix_in,
    input  logic          i_pix_valid,
    input  logic          i_sof,
    output logic [DW-1:0] o_w1,
    output logic [DW-1:0] o_w2,
    output logic [DW-1:0] o_w3,
    output logic [DW-1:0] o_w4,
    output logic [DW-1:0] o_w5,
    output logic [DW-1:0] o_w6,
    output logic [DW-1:0] o_w7,
    output logic [DW-1:0] o_w8,
    output logic [DW-1:0] o_w9,
    output logic          o_win_valid,
    output logic          o_frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_DONE
    } state_t;

    state_t                r_state;
    logic [CW-1:0]         r_col;
    logic [RW-1:0]         r_row;
    logic [2:0][DW-1:0]    r_top;
    logic [2:0][DW-1:0]    r_mid;
    logic [2:0][DW-1:0]    r_bot;
    logic                  r_win_valid;
    logic                  r_frame_done;

    logic [DW-1:0]         r_lb0 [IMG_W];
    logic [DW-1:0]         r_lb1 [IMG_W];

    logic                  w_accept;
    logic [CW-1:0]         w_cur_col;
    logic [RW-1:0]         w_cur_row;
    logic                  w_last_col;
    logic                  w_last_row;
    logic [DW-1:0]         w_lb0_rd;
    logic [DW-1:0]         w_lb1_rd;

    // A sof pixel always restarts at (0,0), whatever the current state.
    assign w_accept   = i_pix_valid && (i_sof || (r_state == S_ACTIVE));
    assign w_cur_col  = i_sof ? '0 : r_col;
    assign w_cur_row  = i_sof ? '0 : r_row;
    assign w_last_col = (w_cur_col == COL_LAST);
    assign w_last_row = (w_cur_row == ROW_LAST);

    // Asynchronous read so the old entry is seen in the same cycle it is overwritten.
    assign w_lb0_rd = r_lb0[w_cur_col];
    assign w_lb1_rd = r_lb1[w_cur_col];

    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_lb1[w_cur_col] <= w_lb0_rd;
            r_lb0[w_cur_col] <= i_pix_in;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_col        <= '0;
            r_row        <= '0;
            r_top        <= '0;
            r_mid        <= '0;
            r_bot        <= '0;
            r_win_valid  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_win_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            if (w_accept) begin
                r_top        <= {r_top[1:0], w_lb1_rd};
                r_mid        <= {r_mid[1:0], w_lb0_rd};
                r_bot        <= {r_bot[1:0], i_pix_in};
                r_win_valid  <= (w_cur_row >= RW'(2)) && (w_cur_col >= CW'(2));
                r_frame_done <= w_last_col && w_last_row;
                if (w_last_col) begin
                    r_col <= '0;
                    r_row <= w_last_row ? '0 : w_cur_row + RW'(1);
                end else begin
                    r_col <= w_cur_col + CW'(1);
                    r_row <= w_cur_row;
                end
                r_state <= (w_last_col && w_last_row) ? S_DONE : S_ACTIVE;
            end
        end
    end

    assign o_w1         = r_top[2];
    assign o_w2         = r_top[1];
    assign o_w3         = r_top[0];
    assign o_w4         = r_mid[2];
    assign o_w5         = r_mid[1];
    assign o_w6         = r_mid[0];
    assign o_w7         = r_bot[2];
    assign o_w8         = r_bot[1];
    assign o_w9         = r_bot[0];
    assign o_win_valid  = r_win_valid;
    assign o_frame_done = r_frame_done;

endmodule

// File: doc/window_3x3_gen.md
# window_3x3_gen

Streaming 3x3 neighbourhood generator for the low-light enhancement pipeline. It accepts a raster-order 8-bit pixel stream and maintains two line buffers plus a 3x3 shift window. For every interior pixel position it presents the nine window taps in parallel, together with a one-cycle valid strobe. It is the upstream producer feeding the nine-input median/rank sorter stage.

## Interface
- IMG_W, 640, pixels per line; minimum 3.
- IMG_H, 480, lines per frame; minimum 3.
- DW, 8, pixel width.
- clk  input  1  rising-edge clock; all logic in this domain.
- rst_n  input  1  synchronous, active-low reset.
- pix_in  input  DW  input pixel, raster order.
- pix_valid  input  1  pix_in is accepted on this cycle; gaps allowed.
- sof  input  1  start of frame; qualified by pix_valid; marks pixel (0,0).
- w1..w9  output  DW each  window taps, row-major: w1 = (r-2,c-2), w2 = (r-2,c-1), w3 = (r-2,c), w4 = (r-1,c-2) … w9 = (r,c); w5 is the centre.
- win_valid  output  1  one-cycle strobe; w1..w9 hold a complete window.
- frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted.

## Operation
- There is no backpressure. Every pix_valid cycle in state ACTIVE is consumed.
- Counters:
  - col counts 0..IMG_W-1 (width $clog2(IMG_W)).
  - row counts 0..IMG_H-1 (width $clog2(IMG_H)).
  - col wraps to 0 and row increments after col = IMG_W-1.
- Line buffers:
  - LB0 holds line r-1 and LB1 holds line r-2, each IMG_W x DW, indexed by col.
  - On each accepted pixel, LB1[col] <= LB0[col] and LB0[col] <= pix_in.
- Window:
  - Three 3-deep column shift registers hold rows r-2, r-1 and r.
  - They shift on each accepted pixel, loading LB1[col], LB0[col] and pix_in.
  - The shift registers do not clear at line start. Stale taps are masked by the valid rule below.
- win_valid is asserted for the accepted pixel (r,c) only when r >= 2 and c >= 2.
  - The centre of that window is (r-1,c-1).
  - This gives exactly (IMG_H-2)*(IMG_W-2) windows per frame.
  - Border pixels produce no windows; there is no padding.
- States:
  - IDLE (after reset): ignore pixels until pix_valid && sof. On that cycle, accept the pixel as (0,0) and go to ACTIVE.
  - ACTIVE: accept pixels. When (IMG_H-1, IMG_W-1) is accepted, pulse frame_done and go to DONE.
  - DONE: ignore pix_valid without sof. On pix_valid && sof, accept the pixel as (0,0) and go to ACTIVE.
- A pix_valid && sof in ACTIVE (early frame restart):
  - Abort the current frame without a frame_done pulse.
  - Treat that pixel as (0,0).
  - Old line-buffer data is never exposed, because row < 2 masks it.
- sof without pix_valid is ignored.
- Reset mid-frame:
  - State returns to IDLE and counters clear.
  - Line-buffer RAM contents are not cleared and are never exposed.

## Timing
- Reset values: w1..w9 = 0, win_valid = 0, frame_done = 0, state = IDLE, row = col = 0.
- Latency is 1 cycle. The pixel (r,c) accepted at edge N appears as w9 from edge N+1, with win_valid high for exactly that cycle.
- frame_done is high in the same cycle as the win_valid of the last window.
- Outputs hold their values between strobes. w1..w9 change only on the cycle after an accepted pixel.
- Line buffers need a read-before-write on the same address in one cycle. Use LUTRAM, or BRAM in read-first mode with the read result registered in the same pipeline stage. Latency must remain 1 cycle as seen at the ports.
- Back-to-back pix_valid gives a window on every cycle along an interior line, with no bubbles at line wrap beyond the two masked border columns.

## Test plan
- Bench uses IMG_W=5, IMG_H=4 and pixel value = r*16+c.
- Continuous frame after sof:
  - Exactly 6 win_valid strobes.
  - First window: w1..w9 = 00,01,02,10,11,12,20,21,22.
  - Last window: w1..w9 = 12,13,14,22,23,24,32,33,34.
  - frame_done coincides with the last window.
- Same frame with random pix_valid gaps (0–3 idle cycles): identical window values and count; win_valid only on the cycle following an accepted pixel.
- Pixels sent before any sof, and extra pixels after frame_done: no win_valid, no frame_done; the next sof frame still produces the 6 correct windows.
- sof asserted at pixel (2,3) of a frame, followed by a full new frame with values +0x80: no frame_done for the aborted frame; first new window w5 = 0x91; no window contains 0x0x or 0x1x/0x2x values from the old frame.
- rst_n low for 1 cycle mid-frame, at row 2: all outputs 0 the next cycle; pixels ignored until sof; the following frame matches the continuous-frame result.
- IMG_W=3, IMG_H=3: exactly one window, w1..w9 = 00,01,02,10,11,12,20,21,22, with frame_done on the same cycle.
